// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad column scanner with 2-flop row sync and frame-based debounce.
// Optional KEYPAD_GHOST_REJECT_EN: frames with more than one key become MULTI instead of lowest-index KEY.
module keypad_scan #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       R3,
    input  logic       R2,
    input  logic       R1,
    input  logic       R0,
    output logic [3:0] C,
    output logic       keypress,
    output logic [4:0] keystat
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [4:0] KEY_MAP [16] = '{
        5'h01, 5'h02, 5'h03, 5'h0A,
        5'h04, 5'h05, 5'h06, 5'h0B,
        5'h07, 5'h08, 5'h09, 5'h0C,
        5'h0E, 5'h00, 5'h0F, 5'h0D
    };
    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;
    state_t          state_q, state_d;
    logic [3:0]      meta_q, meta_d, sync_q, sync_d;
    logic [DW-1:0]   div_q, div_d;
    logic [1:0]      col_q, col_d;
    logic [15:0]     hit_q, hit_d, hit_now, sample;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [4:0]      cand_q, cand_d, stat_q, stat_d, key_code;
    logic            press_q, press_d;
    logic            slot_end, frame_end, is_key, match;
    logic [3:0]      key_idx;
    always_comb begin
        meta_d    = {R3, R2, R1, R0};
        sync_d    = meta_q;
        slot_end  = div_q == DW'(SCAN_DIV - 1);
        frame_end = slot_end && col_q == 2'd3;
        div_d     = slot_end ? '0 : div_q + 1'b1;
        col_d     = slot_end ? col_q + 1'b1 : col_q;
        // Bit r*4+c of the hit map marks key (row r, column c) seen low this frame.
        sample    = {{4{~sync_q[3]}}, {4{~sync_q[2]}}, {4{~sync_q[1]}}, {4{~sync_q[0]}}}
                    & {4{4'b0001 << col_q}};
        hit_now   = hit_q | (slot_end ? sample : '0);
        hit_d     = frame_end ? '0 : hit_now;
        key_idx   = '0;
        for (int i = 15; i >= 0; i--)
            if (hit_now[i]) key_idx = 4'(i);
        key_code  = KEY_MAP[key_idx];
`ifdef KEYPAD_GHOST_REJECT_EN
        is_key    = hit_now != '0 && (hit_now & (hit_now - 1'b1)) == '0;
`else
        is_key    = hit_now != '0;
`endif
        match     = is_key && key_code == cand_q;
        cnt_inc   = cnt_q == CW'(DEBOUNCE_FRAMES) ? cnt_q : cnt_q + 1'b1;
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        stat_d    = stat_q;
        press_d   = press_q;
        if (frame_end) begin
            case (state_q)
                IDLE: if (is_key) begin
                    cand_d  = key_code;
                    cnt_d   = CW'(1);
                    state_d = DEBOUNCE_FRAMES <= 1 ? HELD : PRESS_CHK;
                    stat_d  = DEBOUNCE_FRAMES <= 1 ? key_code : stat_q;
                    press_d = DEBOUNCE_FRAMES <= 1;
                end
                PRESS_CHK: if (match) begin
                    cnt_d   = cnt_inc;
                    state_d = cnt_inc == CW'(DEBOUNCE_FRAMES) ? HELD : PRESS_CHK;
                    stat_d  = cnt_inc == CW'(DEBOUNCE_FRAMES) ? cand_q : stat_q;
                    press_d = cnt_inc == CW'(DEBOUNCE_FRAMES);
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                HELD: if (!match) begin
                    cnt_d   = CW'(1);
                    state_d = DEBOUNCE_FRAMES <= 1 ? IDLE : REL_CHK;
                    stat_d  = DEBOUNCE_FRAMES <= 1 ? 5'h10 : stat_q;
                    press_d = DEBOUNCE_FRAMES > 1;
                end
                default: if (match) begin
                    state_d = HELD;
                end else begin
                    cnt_d   = cnt_inc;
                    state_d = cnt_inc == CW'(DEBOUNCE_FRAMES) ? IDLE : REL_CHK;
                    stat_d  = cnt_inc == CW'(DEBOUNCE_FRAMES) ? 5'h10 : stat_q;
                    press_d = cnt_inc != CW'(DEBOUNCE_FRAMES);
                end
            endcase
        end
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            meta_q  <= 4'hF;
            sync_q  <= 4'hF;
            div_q   <= '0;
            col_q   <= '0;
            hit_q   <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            stat_q  <= 5'h10;
            press_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            div_q   <= div_d;
            col_q   <= col_d;
            hit_q   <= hit_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            stat_q  <= stat_d;
            press_q <= press_d;
        end
    end
    assign C        = ~(4'b0001 << col_q);
    assign keypress = press_q;
    assign keystat  = stat_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad modelled as a 16-bit pressed-key set; outputs checked every cycle against a frame-level debounce model.
module tb_keypad_scan;
    localparam int SD = 4;
    localparam int DF = 3;
    localparam logic [4:0] KMAP [16] = '{
        5'h01, 5'h02, 5'h03, 5'h0A,
        5'h04, 5'h05, 5'h06, 5'h0B,
        5'h07, 5'h08, 5'h09, 5'h0C,
        5'h0E, 5'h00, 5'h0F, 5'h0D
    };
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = '0;
    logic [3:0]  c;
    logic        r0, r1, r2, r3, kp;
    logic [4:0]  ks;
    logic [3:0]  exp_c = 4'b1110;
    logic [4:0]  exp_ks = 5'h10;
    logic        exp_kp = 1'b0;
    int errors = 0, checks = 0, phase = 0, out = 16, run = 0, last = 0, miss = 0;

    // Physical keypad: a row reads low when a pressed key sits in the column being driven low.
    assign r0 = ~|(keys[3:0]   & ~c);
    assign r1 = ~|(keys[7:4]   & ~c);
    assign r2 = ~|(keys[11:8]  & ~c);
    assign r3 = ~|(keys[15:12] & ~c);

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .CLK(clk), .RST_N(rst_n), .R3(r3), .R2(r2), .R1(r1), .R0(r0),
        .C(c), .keypress(kp), .keystat(ks)
    );

    always #5 clk = ~clk;

    // -1 = no key, -2 = multi-key, otherwise key code
    function automatic int frame_result(input logic [15:0] k);
        if (k == '0) return -1;
`ifdef KEYPAD_GHOST_REJECT_EN
        if ($countones(k) > 1) return -2;
`endif
        for (int i = 0; i < 16; i++)
            if (k[i]) return int'(KMAP[i]);
        return -1;
    endfunction

    task automatic tick();
        int res;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            phase = 0; out = 16; run = 0; miss = 0;
        end else begin
            phase = (phase + 1) % 16;
            if (phase == 0) begin
                res = frame_result(keys);
                if (out == 16) begin
                    if (res >= 0 && (run == 0 || res == last)) begin
                        run++;
                        last = res;
                    end else run = 0;
                    if (run >= DF) begin out = last; run = 0; miss = 0; end
                end else begin
                    if (res == out) miss = 0; else miss++;
                    if (miss >= DF) begin out = 16; miss = 0; run = 0; end
                end
            end
        end
        exp_c  = ~(4'b0001 << (phase / 4));
        exp_ks = 5'(out);
        exp_kp = out != 16;
    endtask

    task automatic test_reset();
        keys = 16'h000F;
        rst_n = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if ({c, ks, kp} !== {4'b1110, 5'h10, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold: C=%b keystat=%h keypress=%b, required C=1110 keystat=10 keypress=0", c, ks, kp);
            end
        end
        rst_n = 1'b1;
        repeat (48) begin
            tick();
            checks++;
            if ({c, ks, kp} !== {exp_c, exp_ks, exp_kp}) begin
                errors++;
                $display("FAIL reset_release: C=%b keystat=%h keypress=%b, required C=%b keystat=%h keypress=%b", c, ks, kp, exp_c, exp_ks, exp_kp);
            end
            if (phase == 0 && out == 16) begin
                checks++;
                if (ks !== 5'h10 || kp !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_no_early: keystat=%h keypress=%b, required keystat=10 keypress=0", ks, kp);
                end
            end
        end
        checks++;
`ifdef KEYPAD_GHOST_REJECT_EN
        if (ks !== 5'h10) begin
`else
        if (ks !== 5'h01) begin
`endif
            errors++;
            $display("FAIL reset_row0_frame3: keystat=%h", ks);
        end
        keys = '0;
        repeat (64) begin
            tick();
            checks++;
            if ({c, ks, kp} !== {exp_c, exp_ks, exp_kp}) begin
                errors++;
                $display("FAIL reset_idle: C=%b keystat=%h keypress=%b, required C=%b keystat=%h keypress=%b", c, ks, kp, exp_c, exp_ks, exp_kp);
            end
        end
    endtask

    task automatic test_clean_press();
        keys = 16'h0200;
        repeat (80) begin
            tick();
            checks++;
            if ({c, ks, kp} !== {exp_c, exp_ks, exp_kp}) begin
                errors++;
                $display("FAIL press8: C=%b keystat=%h keypress=%b, required C=%b keystat=%h keypress=%b", c, ks, kp, exp_c, exp_ks, exp_kp);
            end
            if (phase == 0) begin
                checks++;
                if (ks !== 5'h08 && ks !== 5'h10) begin
                    errors++;
                    $display("FAIL press8_code: keystat=%h, required 08 or 10", ks);
                end
            end
        end
        checks++;
        if (ks !== 5'h08 || kp !== 1'b1) begin
            errors++;
            $display("FAIL press8_held: keystat=%h keypress=%b, required 08 1", ks, kp);
        end
        keys = '0;
        repeat (32) tick();
        checks++;
        if (ks !== 5'h08 || kp !== 1'b1) begin
            errors++;
            $display("FAIL release8_early: keystat=%h keypress=%b, required 08 1", ks, kp);
        end
        repeat (16) tick();
        checks++;
        if (ks !== 5'h10 || kp !== 1'b0) begin
            errors++;
            $display("FAIL release8: keystat=%h keypress=%b, required 10 0", ks, kp);
        end
        repeat (16) tick();
    endtask

    task automatic test_bounce();
        logic [4:0] prev;
        int trans = 0;
        prev = ks;
        for (int f = 0; f < 5; f++) begin
            keys = (f == 1) ? 16'h0000 : 16'h8000;
            repeat (16) begin
                tick();
                checks++;
                if ({c, ks, kp} !== {exp_c, exp_ks, exp_kp}) begin
                    errors++;
                    $display("FAIL bounce: C=%b keystat=%h keypress=%b, required C=%b keystat=%h keypress=%b", c, ks, kp, exp_c, exp_ks, exp_kp);
                end
                if (ks !== prev) trans++;
                prev = ks;
            end
        end
        checks++;
        if (trans != 1 || ks !== 5'h0D) begin
            errors++;
            $display("FAIL bounce_once: transitions=%0d keystat=%h, required 1 and 0d", trans, ks);
        end
        keys = '0;
        repeat (64) tick();
    endtask

    task automatic test_key_roll();
        logic [4:0] seq [$];
        logic [4:0] prev;
        int idle_cyc = 0;
        keys = 16'h4000;
        repeat (48) tick();
        checks++;
        if (ks !== 5'h0F) begin
            errors++;
            $display("FAIL roll_eq: keystat=%h, required 0f", ks);
        end
        prev = ks;
        keys = 16'h0008;
        repeat (96) begin
            tick();
            checks++;
            if ({c, ks, kp} !== {exp_c, exp_ks, exp_kp}) begin
                errors++;
                $display("FAIL roll: C=%b keystat=%h keypress=%b, required C=%b keystat=%h keypress=%b", c, ks, kp, exp_c, exp_ks, exp_kp);
            end
            if (ks !== prev) seq.push_back(ks);
            if (ks === 5'h10) idle_cyc++;
            prev = ks;
        end
        checks++;
        if (seq.size() != 2 || seq[0] !== 5'h10 || seq[1] !== 5'h0A || idle_cyc < 1) begin
            errors++;
            $display("FAIL roll_seq: changes=%0d final=%h idle_cycles=%0d, required 10 then 0a with idle>=1", seq.size(), ks, idle_cyc);
        end
        keys = '0;
        repeat (64) tick();
    endtask

    task automatic test_two_keys();
        keys = 16'h0021;
        repeat (64) begin
            tick();
            checks++;
            if ({c, ks, kp} !== {exp_c, exp_ks, exp_kp}) begin
                errors++;
                $display("FAIL two_keys: C=%b keystat=%h keypress=%b, required C=%b keystat=%h keypress=%b", c, ks, kp, exp_c, exp_ks, exp_kp);
            end
        end
        checks++;
`ifdef KEYPAD_GHOST_REJECT_EN
        if (ks !== 5'h10) begin
`else
        if (ks !== 5'h01) begin
`endif
            errors++;
            $display("FAIL two_keys_code: keystat=%h", ks);
        end
        keys = '0;
        repeat (64) tick();
    endtask

    task automatic test_reset_mid();
        keys = 16'h2000;
        repeat (24) tick();
        rst_n = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if ({c, ks, kp} !== {4'b1110, 5'h10, 1'b0}) begin
                errors++;
                $display("FAIL midreset_hold: C=%b keystat=%h keypress=%b, required C=1110 keystat=10 keypress=0", c, ks, kp);
            end
        end
        rst_n = 1'b1;
        repeat (48) begin
            tick();
            checks++;
            if ({c, ks, kp} !== {exp_c, exp_ks, exp_kp}) begin
                errors++;
                $display("FAIL midreset: C=%b keystat=%h keypress=%b, required C=%b keystat=%h keypress=%b", c, ks, kp, exp_c, exp_ks, exp_kp);
            end
        end
        checks++;
        if (ks !== 5'h00 || kp !== 1'b1) begin
            errors++;
            $display("FAIL midreset_key0: keystat=%h keypress=%b, required 00 1", ks, kp);
        end
        keys = '0;
        repeat (64) tick();
    endtask

    task automatic test_random();
        int r;
        for (int f = 0; f < 60; f++) begin
            r = $urandom_range(0, 9);
            if (r < 2) keys = '0;
            else if (r >= 7 && r < 9) keys = 16'(1) << $urandom_range(0, 15);
            else if (r == 9) keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            repeat (16) begin
                tick();
                checks++;
                if ({c, ks, kp} !== {exp_c, exp_ks, exp_kp}) begin
                    errors++;
                    $display("FAIL random f%0d keys=%h: C=%b keystat=%h keypress=%b, required C=%b keystat=%h keypress=%b", f, keys, c, ks, kp, exp_c, exp_ks, exp_kp);
                end
            end
        end
        keys = '0;
        repeat (64) tick();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_key_roll();
        test_two_keys();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
